// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Imported by the interface, the PC helper and the top.
package instr_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_HALTED
  } state_e;

  localparam logic [31:0] ENC_FIRST   = 32'h37;
  localparam logic [31:0] ENC_HALT    = 32'h3F;
  localparam logic        NEXT_PC_IMM = 1'b1;
  localparam logic        NEXT_PC_4   = 1'b0;
  localparam logic [31:0] PC_INC      = 32'd4;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Memory and decoder bundle of the fetch sequencer.
// master = sequencer side, slave = memory/decoder side.
interface instr_fetch_sequencer_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] mem_rimm;
  logic [31:0] dec_instr;
  logic        dec_valid;
  logic        dec_next_pc;
  logic        dec_is_halt;

  modport master (
    output mem_req,
    output mem_addr,
    output dec_instr,
    output dec_valid,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    input  mem_rimm,
    input  dec_next_pc,
    input  dec_is_halt
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  dec_instr,
    input  dec_valid,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    output mem_rimm,
    output dec_next_pc,
    output dec_is_halt
  );

endinterface

// File: rtl/instr_fetch_sequencer_pc_next_calc.sv
// Combinational next-PC select: PC+imm or PC+4.
// Sums are 32-bit modulo, wrap-around is silent.
module pc_next_calc
  import instr_fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        sel,
  output logic [31:0] next_pc
);

  assign next_pc = (sel == NEXT_PC_IMM) ? pc + imm
                                        : pc + PC_INC;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch/decode sequencer: one outstanding fetch,
// one-cycle decode slot, restartable after halt.
module instr_fetch_sequencer
  import instr_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  instr_fetch_sequencer_if.master  bus,
  output logic [31:0]              pc,
  output logic                     halted,
  output logic [31:0]              retired
);

  state_e      state;
  logic [31:0] instr_q;
  logic [31:0] imm_q;
  logic [31:0] pc_nxt;
  logic        req_q;
  logic        dval_q;

  pc_next_calc u_pc_next (
    .pc      (pc),
    .imm     (imm_q),
    .sel     (bus.dec_next_pc),
    .next_pc (pc_nxt)
  );

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = pc;
  assign bus.dec_instr = instr_q;
  assign bus.dec_valid = dval_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      imm_q   <= '0;
      req_q   <= 1'b0;
      dval_q  <= 1'b0;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.mem_gnt) begin
            state <= S_WAIT;
            req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            instr_q <= bus.mem_rdata;
            imm_q   <= bus.mem_rimm;
            dval_q  <= 1'b1;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          dval_q <= 1'b0;
          if (retired != '1)
            retired <= retired + 32'd1;
          if (bus.dec_is_halt) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else begin
            pc    <= pc_nxt;
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        S_HALTED: begin
          if (start) begin
            state   <= S_FETCH;
            halted  <= 1'b0;
            req_q   <= 1'b1;
            pc      <= RESET_PC;
            retired <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench: memory/decoder stand-in driven by $urandom,
// compared against a transaction-level PC/retire model.
module tb_instr_fetch_sequencer;
  import instr_fetch_sequencer_pkg::*;

  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] pc_a, pc_b;
  logic        halted_a, halted_b;
  logic [31:0] retired_a, retired_b;

  instr_fetch_sequencer_if bus_a ();
  instr_fetch_sequencer_if bus_b ();

  instr_fetch_sequencer #(.RESET_PC(RPC_A)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_a),
    .bus     (bus_a),
    .pc      (pc_a),
    .halted  (halted_a),
    .retired (retired_a)
  );

  instr_fetch_sequencer #(.RESET_PC(RPC_B)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_b),
    .bus     (bus_b),
    .pc      (pc_b),
    .halted  (halted_b),
    .retired (retired_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic        exp_halt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus_a.mem_gnt     = 1'b0;
    bus_a.mem_rvalid  = 1'b0;
    bus_a.mem_rdata   = '0;
    bus_a.mem_rimm    = '0;
    bus_a.dec_next_pc = 1'b0;
    bus_a.dec_is_halt = 1'b0;
    bus_b.mem_gnt     = 1'b0;
    bus_b.mem_rvalid  = 1'b0;
    bus_b.mem_rdata   = '0;
    bus_b.mem_rimm    = '0;
    bus_b.dec_next_pc = 1'b0;
    bus_b.dec_is_halt = 1'b0;
  endtask

  task automatic model_reset();
    exp_pc   = RPC_A;
    exp_ret  = '0;
    exp_halt = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] enc,
                           input logic [31:0] imm,
                           input bit          sel,
                           input int          gdly,
                           input int          rdly);
    int n = 0;
    bit hlt;
    hlt = (enc == ENC_HALT);
    while (bus_a.mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    chk("fetch_addr", bus_a.mem_addr, exp_pc);
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      chk("req_hold", {31'd0, bus_a.mem_req}, 32'd1);
      chk("addr_hold", bus_a.mem_addr, exp_pc);
      chk("no_dval_fetch", {31'd0, bus_a.dec_valid}, 32'd0);
    end
    bus_a.mem_gnt    = 1'b1;
    bus_a.mem_rvalid = 1'b1;
    bus_a.mem_rdata  = $urandom;
    @(negedge clk);
    bus_a.mem_gnt    = 1'b0;
    bus_a.mem_rvalid = 1'b0;
    chk("req_drop", {31'd0, bus_a.mem_req}, 32'd0);
    for (int i = 0; i < rdly; i++) begin
      start_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("no_dval_wait", {31'd0, bus_a.dec_valid}, 32'd0);
    end
    start_a          = 1'b0;
    bus_a.mem_rvalid = 1'b1;
    bus_a.mem_rdata  = enc;
    bus_a.mem_rimm   = imm;
    @(negedge clk);
    bus_a.mem_rvalid = 1'b0;
    bus_a.mem_rdata  = $urandom;
    bus_a.mem_rimm   = $urandom;
    chk("dval", {31'd0, bus_a.dec_valid}, 32'd1);
    chk("dec_instr", bus_a.dec_instr, enc);
    bus_a.dec_next_pc = sel;
    bus_a.dec_is_halt = hlt;
    @(negedge clk);
    bus_a.dec_next_pc = 1'b0;
    bus_a.dec_is_halt = 1'b0;
    if (exp_ret != 32'hFFFF_FFFF)
      exp_ret = exp_ret + 1;
    if (hlt)
      exp_halt = 1'b1;
    else
      exp_pc = sel ? exp_pc + imm : exp_pc + 32'd4;
    chk("dval_drop", {31'd0, bus_a.dec_valid}, 32'd0);
    chk("instr_hold", bus_a.dec_instr, enc);
    chk("retired", retired_a, exp_ret);
    chk("halted", {31'd0, halted_a}, {31'd0, exp_halt});
    chk("pc", pc_a, exp_pc);
    chk("next_req", {31'd0, bus_a.mem_req}, {31'd0, !hlt});
  endtask

  task automatic restart();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    model_reset();
    chk("rs_addr", bus_a.mem_addr, exp_pc);
    chk("rs_req", {31'd0, bus_a.mem_req}, 32'd1);
    chk("rs_ret", retired_a, 32'd0);
    chk("rs_halt", {31'd0, halted_a}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req", {31'd0, bus_a.mem_req}, 32'd0);
    chk("rst_dval", {31'd0, bus_a.dec_valid}, 32'd0);
    chk("rst_instr", bus_a.dec_instr, 32'd0);
    chk("rst_halt", {31'd0, halted_a}, 32'd0);
    chk("rst_ret", retired_a, 32'd0);
    chk("rst_pc", pc_a, RPC_A);
    chk("rst_pc_b", pc_b, RPC_B);
  endtask

  initial begin
    logic [31:0] enc;
    drive_idle();
    #2;
    apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_req", {31'd0, bus_a.mem_req}, 32'd0);
      chk("idle_pc", pc_a, RPC_A);
    end

    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_req", {31'd0, bus_b.mem_req}, 32'd1);
    chk("b_addr", bus_b.mem_addr, RPC_B);
    bus_b.mem_gnt = 1'b1;
    @(negedge clk);
    bus_b.mem_gnt    = 1'b0;
    bus_b.mem_rvalid = 1'b1;
    bus_b.mem_rdata  = 32'h0;
    bus_b.mem_rimm   = $urandom;
    @(negedge clk);
    bus_b.mem_rvalid = 1'b0;
    chk("b_dval", {31'd0, bus_b.dec_valid}, 32'd1);
    @(negedge clk);
    chk("b_wrap_req", {31'd0, bus_b.mem_req}, 32'd1);
    chk("b_wrap_addr", bus_b.mem_addr, 32'h0);

    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    fetch_one(32'h00, 32'h0, 1'b0, 0, 0);
    fetch_one(32'h01, 32'h0, 1'b0, 0, 0);
    fetch_one(ENC_HALT, 32'h0, 1'b0, 0, 0);
    chk("prog_ret", retired_a, 32'd3);
    chk("prog_pc", pc_a, 32'd8);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("halt_stay", {31'd0, halted_a}, 32'd1);
      chk("halt_noreq", {31'd0, bus_a.mem_req}, 32'd0);
      chk("halt_pc", pc_a, 32'd8);
    end
    restart();

    fetch_one(ENC_FIRST, 32'h0000_0010, NEXT_PC_IMM, 0, 0);
    chk("imm_addr", bus_a.mem_addr, 32'h10);
    fetch_one(32'h1234_5678, 32'h0, NEXT_PC_4, 5, 2);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0)
        enc = ENC_HALT;
      else begin
        enc = $urandom;
        if (enc == ENC_HALT) enc = ENC_FIRST;
      end
      fetch_one(enc, $urandom, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      if (exp_halt) begin
        @(negedge clk);
        chk("r_halt_noreq", {31'd0, bus_a.mem_req}, 32'd0);
        restart();
      end
    end

    fetch_one(32'h0000_0055, 32'h0, NEXT_PC_4, 0, 0);
    chk("pre_ret_nz", {31'd0, retired_a != 0}, 32'd1);
    bus_a.mem_gnt = 1'b1;
    @(negedge clk);
    bus_a.mem_gnt = 1'b0;
    #2;
    apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.mem_rvalid = 1'b1;
    bus_a.mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_a.mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_dval", {31'd0, bus_a.dec_valid}, 32'd0);
      chk("late_req", {31'd0, bus_a.mem_req}, 32'd0);
      chk("late_ret", retired_a, 32'd0);
      chk("late_instr", bus_a.dec_instr, 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
